// File: rtl/mura_seq_pkg.sv
// Shared types and default sizes for the mura_seq_ctrl word-to-bit sequencer.
package mura_seq_pkg;

  localparam int unsigned W_DEFAULT     = 8;
  localparam int unsigned DIV_W_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    WAIT,
    STEP,
    CAPT,
    DONE
  } state_t;

endpackage

// File: rtl/mura_seq_ctrl_if.sv
// Word-level valid/ready channels between host logic (master) and the sequencer (slave).
interface mura_seq_ctrl_if
  import mura_seq_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/mura_step_timer.sv
// Loadable down-counter used to space automaton steps; done marks the last idle cycle.
module mura_step_timer
  import mura_seq_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] val,
  output logic             done
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (cnt != '0) begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign done = (cnt == '0) || (cnt == DIV_W'(1));

endmodule

// File: rtl/mura_seq_ctrl.sv
// Feeds a W-bit word LSB-first into the mod-3 automaton and returns its W y samples.
// Define MURA_SEQ_DIV_EN to add step_div idle cycles (WAIT state) before every step.
module mura_seq_ctrl
  import mura_seq_pkg::*;
#(
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  mura_seq_ctrl_if.slave   bus,
  output logic             fsm_rst_n,
  output logic             fsm_en,
  output logic             fsm_a,
  input  logic             fsm_y
`ifdef MURA_SEQ_DIV_EN
  ,
  input  logic [DIV_W-1:0] step_div
`endif
);

  localparam int unsigned IDX_W = (W > 1) ? $clog2(W) : 1;

  if (W < 2 || DIV_W < 1) begin : g_bad_param
    $error("mura_seq_ctrl: W must be >= 2 and DIV_W >= 1");
  end

  state_t           state, state_nxt;
  logic             live_q;
  logic [W-1:0]     data_q;
  logic [W-1:0]     res_q;
  logic [IDX_W-1:0] idx_q;
  logic             accept;
  logic             last_step;
  logic             wait_needed;

  assign accept    = bus.in_valid & bus.in_ready;
  assign last_step = (idx_q == IDX_W'(W - 1));

`ifdef MURA_SEQ_DIV_EN
  logic [DIV_W-1:0] div_q;
  logic             timer_load;
  logic             timer_done;

  assign wait_needed = (div_q != '0);
  assign timer_load  = (state_nxt == WAIT) && (state != WAIT);

  mura_step_timer #(.DIV_W(DIV_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .val  (div_q),
    .done (timer_done)
  );
`else
  assign wait_needed = 1'b0;
`endif

  // live_q keeps the decoded outputs at their reset values for the whole reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      live_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      live_q <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CLR;
      CLR:  state_nxt = wait_needed ? WAIT : STEP;
`ifdef MURA_SEQ_DIV_EN
      WAIT: if (timer_done) state_nxt = STEP;
`endif
      STEP: state_nxt = CAPT;
      CAPT: state_nxt = last_step ? DONE : (wait_needed ? WAIT : STEP);
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      res_q  <= '0;
      idx_q  <= '0;
`ifdef MURA_SEQ_DIV_EN
      div_q  <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          data_q <= bus.in_data;
          res_q  <= '0;
`ifdef MURA_SEQ_DIV_EN
          div_q  <= step_div;
`endif
        end
        CLR:  idx_q <= '0;
        CAPT: begin
          res_q[idx_q] <= fsm_y;
          if (!last_step) idx_q <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = live_q && (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = (state == DONE) ? res_q : '0;
  assign fsm_rst_n     = live_q && (state != CLR);
  assign fsm_en        = (state == STEP);
  assign fsm_a         = fsm_en & data_q[idx_q];

endmodule

// File: tb/tb_mura_seq_ctrl.sv
// Directed bench for mura_seq_ctrl with a behavioural mod-3 automaton on the fsm_* side.
module tb_mura_seq_ctrl;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fsm_rst_n, fsm_en, fsm_a, fsm_y;
`ifdef MURA_SEQ_DIV_EN
  logic [3:0] step_div = 4'd0;
`endif

  int total = 0;
  int bad   = 0;

  mura_seq_ctrl_if #(.W(W)) bus ();

  always #5 clk = ~clk;

  mura_seq_ctrl #(.W(W), .DIV_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_rst_n (fsm_rst_n),
    .fsm_en    (fsm_en),
    .fsm_a     (fsm_a),
    .fsm_y     (fsm_y)
`ifdef MURA_SEQ_DIV_EN
    ,
    .step_div  (step_div)
`endif
  );

  // Reference automaton: y = (ones seen since clear) mod 3 != 0, updated on en.
  logic [1:0] m_cnt;
  logic       m_y;
  assign fsm_y = m_y;

  function automatic logic [1:0] mod3_next(input logic [1:0] c, input logic a);
    if (!a) return c;
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  always @(posedge clk) begin
    if (!fsm_rst_n) begin
      m_cnt <= 2'd0;
      m_y   <= 1'b0;
    end else if (fsm_en) begin
      m_cnt <= mod3_next(m_cnt, fsm_a);
      m_y   <= (mod3_next(m_cnt, fsm_a) != 2'd0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge where out_valid is first seen.
  task automatic run_word(input logic [W-1:0] d, output int lat, output int ens,
                          output int rstl, output int gmin, output int gmax, output bit to);
    int last;
    int waited;
    lat = 0; ens = 0; rstl = 0; gmin = 1000; gmax = 0; to = 1'b0;
    last = -1; waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      to = 1'b1;
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    while (lat < 300) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat++;
      if (!fsm_rst_n) rstl++;
      if (fsm_en) begin
        ens++;
        if (last >= 0) begin
          if (lat - last < gmin) gmin = lat - last;
          if (lat - last > gmax) gmax = lat - last;
        end
        last = lat;
      end
      if (bus.out_valid) return;
    end
    to = 1'b1;
  endtask

  initial begin
    int lat, ens, rstl, gmin, gmax;
    bit to;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_in_ready",  32'(bus.in_ready),  0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data",  32'(bus.out_data),  0);
    check("rst_fsm_rst_n", 32'(fsm_rst_n),     0);
    check("rst_fsm_en",    32'(fsm_en),        0);
    check("rst_fsm_a",     32'(fsm_a),         0);

    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready",  32'(bus.in_ready), 1);
    check("idle_fsm_rst_n", 32'(fsm_rst_n),    1);

    run_word(8'h07, lat, ens, rstl, gmin, gmax, to);
    check("w07_timeout", 32'(to), 0);
    check("w07_data",    32'(bus.out_data), 32'h03);
    check("w07_latency", lat,  18);
    check("w07_en_cnt",  ens,  8);
    check("w07_rst_low", rstl, 1);
    check("w07_gap",     gmin, 2);
    @(negedge clk);
    check("w07_released", 32'(bus.out_valid), 0);

    run_word(8'hFF, lat, ens, rstl, gmin, gmax, to);
    check("wff_timeout", 32'(to), 0);
    check("wff_data",    32'(bus.out_data), 32'hDB);
    @(negedge clk);
    run_word(8'h01, lat, ens, rstl, gmin, gmax, to);
    check("w01_timeout", 32'(to), 0);
    check("w01_data",    32'(bus.out_data), 32'hFF);
    @(negedge clk);

    run_word(8'h00, lat, ens, rstl, gmin, gmax, to);
    check("w00_timeout", 32'(to), 0);
    check("w00_data",    32'(bus.out_data), 32'h00);
    check("w00_rst_low", rstl, 1);
    @(negedge clk);

    // Back-pressure: result held while a new word waits on in_valid.
    bus.out_ready = 1'b0;
    run_word(8'h07, lat, ens, rstl, gmin, gmax, to);
    check("bp_timeout", 32'(to), 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    repeat (10) begin
      @(negedge clk);
      check("bp_data",      32'(bus.out_data),  32'h03);
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_in_ready",  32'(bus.in_ready),  0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_after_hs_out_valid", 32'(bus.out_valid), 0);
    check("bp_after_hs_in_ready",  32'(bus.in_ready),  1);
    run_word(8'hFF, lat, ens, rstl, gmin, gmax, to);
    check("bp2_timeout", 32'(to), 0);
    check("bp2_data",    32'(bus.out_data), 32'hDB);
    check("bp2_latency", lat, 18);
    @(negedge clk);

    // Reset during step 4 (index 3) of 8'hFF.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_step_en", 32'(fsm_en), 1);
    check("mid_step_a",  32'(fsm_a),  1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready",  32'(bus.in_ready),  0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check("mid_rst_out_data",  32'(bus.out_data),  0);
    check("mid_rst_fsm_rst_n", 32'(fsm_rst_n),     0);
    check("mid_rst_fsm_en",    32'(fsm_en),        0);
    check("mid_rst_fsm_a",     32'(fsm_a),         0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready",  32'(bus.in_ready),  1);
    check("post_rst_out_valid", 32'(bus.out_valid), 0);
    run_word(8'h07, lat, ens, rstl, gmin, gmax, to);
    check("post_rst_timeout", 32'(to), 0);
    check("post_rst_data",    32'(bus.out_data), 32'h03);
    @(negedge clk);

`ifdef MURA_SEQ_DIV_EN
    step_div = 4'd3;
    run_word(8'h07, lat, ens, rstl, gmin, gmax, to);
    step_div = 4'd0;
    check("div_timeout", 32'(to), 0);
    check("div_data",    32'(bus.out_data), 32'h03);
    check("div_latency", lat,  42);
    check("div_en_cnt",  ens,  8);
    check("div_gap_min", gmin, 5);
    check("div_gap_max", gmax, 5);
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mura_seq_ctrl.md
Name: mura_seq_ctrl

Overview:
Sequencer that drives the team's three-state mod-3 Moore automaton (ports clk, rst_n, en, a, y) from a word-level stream. Behaviour of that automaton: y registered on each en strobe, y=1 iff count of ones seen since its reset mod 3 is non-zero.
- Accepts a W-bit word via valid/ready and clears the automaton.
- Feeds the bits LSB-first as single-cycle en strobes and captures y after each step.
- Returns the W captured y bits as one result word via valid/ready.
- Sits between the word-level host logic and the bit-serial automaton instance.

Parameters:
W, 8, word width and number of automaton steps per transaction (W >= 2).
DIV_W, 4, width of step_div (only meaningful with MURA_SEQ_DIV_EN).

Ports:
clk  in  1  clock.
rst  in  1  reset.
in_valid  in  1  input word valid.
in_ready  out  1  controller can accept a word.
in_data  in  W  input bits, bit 0 fed first.
out_valid  out  1  result word valid.
out_ready  in  1  consumer accepts result.
out_data  out  W  out_data[i] = automaton y after step i.
fsm_rst_n  out  1  active-low clear to the automaton.
fsm_en  out  1  automaton step strobe.
fsm_a  out  1  automaton input bit.
fsm_y  in  1  automaton output.
step_div  in  DIV_W  idle cycles between steps (only with MURA_SEQ_DIV_EN).
- Interface decision: one clock; reset is synchronous and active-high.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, fsm_rst_n=0, fsm_en=0, fsm_a=0, state=IDLE, bit index=0. The automaton is held cleared while rst is high.
- All outputs are registered or decoded from the state register only.
- IDLE:
  - in_ready=1, fsm_rst_n=1.
  - On in_valid & in_ready: latch in_data, go to CLR.
- CLR:
  - fsm_rst_n=0 for exactly one cycle, index cleared, then go to STEP.
- STEP:
  - fsm_en=1, fsm_a=latched_data[index] for one cycle, then go to CAPT.
- CAPT:
  - res[index] <= fsm_y.
  - If index==W-1, go to DONE; else increment index and go to STEP.
- DONE:
  - out_valid=1, out_data=res, both held stable until out_ready.
  - On handshake, go to IDLE.
- Outside STEP: fsm_en=0 and fsm_a=0.
- Outside CLR and reset: fsm_rst_n=1.
- Latency: out_valid rises 2W+2 cycles after the input handshake cycle (W=8: 18).
- Back-pressure:
  - in_valid while busy is ignored; in_ready=0 in all states except IDLE.
  - out_ready low keeps DONE indefinitely.
- Back-to-back: in_ready is only asserted in IDLE, so a new word is accepted at earliest the cycle after the out handshake.
- Every transaction starts with CLR, so no automaton state carries over between words.
- rst mid-transaction: immediate return to reset values, word discarded, no out_valid.

Optional Feature:
MURA_SEQ_DIV_EN
- With it:
  - step_div port present; its value is latched at input handshake.
  - A WAIT state inserts step_div idle cycles (fsm_en=0) before each STEP, including the first.
  - Latency becomes 2W+2+W*step_div.
  - step_div=0 is identical to the feature-off case.
- Without it:
  - No step_div port, no WAIT state, no divider counter.
  - Timing exactly as in Behaviour.

Decomposition:
- Package mura_seq_pkg: state enum (IDLE, CLR, WAIT, STEP, CAPT, DONE), default W and DIV_W constants.
- Sub-module mura_step_timer (loadable down-counter, done flag): instantiated only under MURA_SEQ_DIV_EN.
- Everything else lives in the top module.

Test Plan:
- in_data=8'h07, out_ready=1 -> out_data=8'h03, out_valid exactly 18 cycles after accept, fsm_en pulses=8.
- in_data=8'hFF then in_data=8'h01 -> results 8'hDB then 8'hFF. The second result proves CLR cleared the automaton.
- in_data=8'h00 -> out_data=8'h00; fsm_rst_n low exactly one cycle per transaction.
- Hold out_ready=0 for 10 cycles with in_valid=1 and new data -> out_data stable, in_ready=0, second word accepted only after the out handshake.
- Assert rst during step 4 of 8'hFF -> next cycle all outputs at reset values. A following 8'h07 yields 8'h03.
- MURA_SEQ_DIV_EN, step_div=3, in_data=8'h07 -> 8'h03 after 18+24=42 cycles; fsm_en pulses spaced 5 cycles apart.
